// File: rtl/apb_uart_pkg.sv
// -----------------------------------------------------------------------------
// apb_uart_pkg
// Shared definitions for the APB UART register front-end:
//   - register byte offsets and the decoded register selector
//   - STATUS / CTRL / CLR bit positions
//   - reset values of CTRL and BAUD
// -----------------------------------------------------------------------------
package apb_uart_pkg;

   // Register byte offsets (word aligned)
   localparam logic [7:0] OFF_TXDATA = 8'h00;
   localparam logic [7:0] OFF_RXDATA = 8'h04;
   localparam logic [7:0] OFF_STATUS = 8'h08;
   localparam logic [7:0] OFF_CTRL   = 8'h0C;
   localparam logic [7:0] OFF_BAUD   = 8'h10;
   localparam logic [7:0] OFF_CLR    = 8'h14;

   // STATUS bit positions
   localparam int unsigned ST_TX_FULL   = 0;
   localparam int unsigned ST_TX_EMPTY  = 1;
   localparam int unsigned ST_RX_NEMPTY = 2;
   localparam int unsigned ST_RX_FULL   = 3;
   localparam int unsigned ST_OVERRUN   = 4;
   localparam int unsigned ST_RXCNT_LSB = 8;

   // CTRL bit positions and width
   localparam int unsigned CTRL_UART_EN = 0;
   localparam int unsigned CTRL_RXIE    = 1;
   localparam int unsigned CTRL_TXIE    = 2;
   localparam int unsigned CTRL_W       = 3;

   // CLR bit that clears the sticky overrun flag
   localparam int unsigned CLR_OVERRUN  = 4;

   // Reset values
   localparam logic [CTRL_W-1:0] CTRL_RST = 3'b000;
   localparam int unsigned       BAUD_RST = 0;

   typedef enum logic [2:0] {
      SEL_TXDATA = 3'd0,
      SEL_RXDATA = 3'd1,
      SEL_STATUS = 3'd2,
      SEL_CTRL   = 3'd3,
      SEL_BAUD   = 3'd4,
      SEL_CLR    = 3'd5,
      SEL_NONE   = 3'd6
   } reg_sel_e;

   // Map a word-aligned byte offset onto a register selector
   function automatic reg_sel_e decode_sel(input logic [7:0] off);
      reg_sel_e sel;
      case (off)
         OFF_TXDATA: sel = SEL_TXDATA;
         OFF_RXDATA: sel = SEL_RXDATA;
         OFF_STATUS: sel = SEL_STATUS;
         OFF_CTRL:   sel = SEL_CTRL;
         OFF_BAUD:   sel = SEL_BAUD;
         OFF_CLR:    sel = SEL_CLR;
         default:    sel = SEL_NONE;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/apb_uart_sync_fifo.sv
// -----------------------------------------------------------------------------
// apb_uart_sync_fifo
// Single-clock FIFO with first-word-fall-through read port.
//   clk_i, rst_ni   clock, synchronous active-low reset (empties the FIFO)
//   push_i, wdata_i write request; accepted when not full or when a pop
//                   happens in the same cycle
//   pop_i           read request; ignored when empty
//   rdata_o         head entry (undefined while empty)
//   full_o, empty_o, count_o  occupancy
// DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module apb_uart_sync_fifo
   import apb_uart_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic [WIDTH-1:0]         wdata_i,
   output logic [WIDTH-1:0]         rdata_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push_s, do_pop_s;

   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == CW'(0));
   assign count_o = count_q;
   assign rdata_o = mem_q[rd_ptr_q];

   // A pop frees a slot in the same cycle, so a push into a full FIFO is
   // still accepted when it coincides with a pop.
   assign do_pop_s  = pop_i & ~empty_o;
   assign do_push_s = push_i & (~full_o | do_pop_s);

   // Next-state pointers and occupancy
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push_s) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (do_pop_s) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({do_push_s, do_pop_s})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Pointer and occupancy registers
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         wr_ptr_q <= AW'(0);
         rd_ptr_q <= AW'(0);
         count_q  <= CW'(0);
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage array; content is don't-care until written
   always_ff @(posedge clk_i) begin
      if (do_push_s && rst_ni) begin
         mem_q[wr_ptr_q] <= wdata_i;
      end
   end

endmodule

// File: rtl/apb_uart_regif.sv
// -----------------------------------------------------------------------------
// apb_uart_regif
// APB3 slave register front-end for a UART with TX/RX byte FIFOs.
//   PCLK, PRESETN        clock, synchronous active-low reset
//   PSEL..PWDATA         APB request; PRDATA/PREADY/PSLVERR response
//                        (zero wait states, PRDATA/PSLVERR combinational)
//   TX_DATA/TX_VALID/TX_READY  byte stream to the bit engine (head of TX FIFO)
//   RX_DATA/RX_VALID     received byte push strobe from the bit engine
//   BAUD_VAL, UART_EN    configuration to the bit engine
//   INT                  registered interrupt request
// -----------------------------------------------------------------------------
module apb_uart_regif
   import apb_uart_pkg::*;
#(
   parameter int ADDR_W     = 5,
   parameter int FIFO_DEPTH = 16,
   parameter int BAUD_W     = 13
) (
   input  logic              PCLK,
   input  logic              PRESETN,
   input  logic              PSEL,
   input  logic              PENABLE,
   input  logic              PWRITE,
   input  logic [ADDR_W-1:0] PADDR,
   input  logic [31:0]       PWDATA,
   output logic [31:0]       PRDATA,
   output logic              PREADY,
   output logic              PSLVERR,
   output logic [7:0]        TX_DATA,
   output logic              TX_VALID,
   input  logic              TX_READY,
   input  logic [7:0]        RX_DATA,
   input  logic              RX_VALID,
   output logic [BAUD_W-1:0] BAUD_VAL,
   output logic              UART_EN,
   output logic              INT
);
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   logic              acc_s;
   reg_sel_e          sel_s;
   logic [31:0]       rdata_s, status_s;
   logic              err_s, tx_push_s, tx_pop_s, rx_pop_s;
   logic              ctrl_we_s, baud_we_s, clr_ov_s, ov_set_s;
   logic              tx_full_s, tx_empty_s, rx_full_s, rx_empty_s;
   logic [7:0]        rx_head_s;
   logic [CNT_W-1:0]  rx_count_s, unused_tx_count_s;
   logic              unused_bits_s;
   logic [CTRL_W-1:0] ctrl_q, ctrl_d;
   logic [BAUD_W-1:0] baud_q, baud_d;
   logic              ov_q, ov_d, int_q, int_d;

   // An access in progress while reset is asserted is ignored entirely.
   assign acc_s    = PSEL & PENABLE & PRESETN;
   assign sel_s    = decode_sel(8'({PADDR[ADDR_W-1:2], 2'b00}));
   assign tx_pop_s = ~tx_empty_s & TX_READY;
   // A full RX FIFO drops the byte only when no read frees a slot this cycle.
   assign ov_set_s = RX_VALID & rx_full_s & ~rx_pop_s;
   assign unused_bits_s = ^{PWDATA[31:BAUD_W], PADDR[1:0]};

   // STATUS word assembly
   always_comb begin
      status_s                          = 32'h0;
      status_s[ST_TX_FULL]              = tx_full_s;
      status_s[ST_TX_EMPTY]             = tx_empty_s;
      status_s[ST_RX_NEMPTY]            = ~rx_empty_s;
      status_s[ST_RX_FULL]              = rx_full_s;
      status_s[ST_OVERRUN]              = ov_q;
      status_s[ST_RXCNT_LSB +: 8]       = 8'(rx_count_s);
   end

   // APB decode: read data, error response and write/pop strobes
   always_comb begin
      rdata_s   = 32'h0;
      err_s     = 1'b0;
      tx_push_s = 1'b0;
      rx_pop_s  = 1'b0;
      ctrl_we_s = 1'b0;
      baud_we_s = 1'b0;
      clr_ov_s  = 1'b0;
      if (acc_s) begin
         case (sel_s)
            SEL_TXDATA: begin
               if (PWRITE && !tx_full_s) begin
                  tx_push_s = 1'b1;
               end else begin
                  err_s = 1'b1;
               end
            end
            SEL_RXDATA: begin
               if (!PWRITE && !rx_empty_s) begin
                  rdata_s  = {24'h0, rx_head_s};
                  rx_pop_s = 1'b1;
               end else begin
                  err_s = 1'b1;
               end
            end
            SEL_STATUS: begin
               if (PWRITE) begin
                  err_s = 1'b1;
               end else begin
                  rdata_s = status_s;
               end
            end
            SEL_CTRL: begin
               if (PWRITE) begin
                  ctrl_we_s = 1'b1;
               end else begin
                  rdata_s = 32'(ctrl_q);
               end
            end
            SEL_BAUD: begin
               if (PWRITE) begin
                  baud_we_s = 1'b1;
               end else begin
                  rdata_s = 32'(baud_q);
               end
            end
            SEL_CLR: begin
               if (PWRITE) begin
                  clr_ov_s = PWDATA[CLR_OVERRUN];
               end else begin
                  err_s = 1'b1;
               end
            end
            default: err_s = 1'b1;
         endcase
      end else begin
         err_s = 1'b0;
      end
   end

   // Register next-state; overrun set wins over a same-cycle clear
   always_comb begin
      ctrl_d = ctrl_we_s ? PWDATA[CTRL_W-1:0] : ctrl_q;
      baud_d = baud_we_s ? PWDATA[BAUD_W-1:0] : baud_q;
      if (ov_set_s) begin
         ov_d = 1'b1;
      end else if (clr_ov_s) begin
         ov_d = 1'b0;
      end else begin
         ov_d = ov_q;
      end
      int_d = (ctrl_q[CTRL_RXIE] & ~rx_empty_s) |
              (ctrl_q[CTRL_TXIE] & tx_empty_s) | ov_q;
   end

   // Control, baud, overrun and interrupt registers
   always_ff @(posedge PCLK) begin
      if (!PRESETN) begin
         ctrl_q <= CTRL_RST;
         baud_q <= BAUD_W'(BAUD_RST);
         ov_q   <= 1'b0;
         int_q  <= 1'b0;
      end else begin
         ctrl_q <= ctrl_d;
         baud_q <= baud_d;
         ov_q   <= ov_d;
         int_q  <= int_d;
      end
   end

   apb_uart_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk_i   (PCLK),
      .rst_ni  (PRESETN),
      .push_i  (tx_push_s),
      .pop_i   (tx_pop_s),
      .wdata_i (PWDATA[7:0]),
      .rdata_o (TX_DATA),
      .full_o  (tx_full_s),
      .empty_o (tx_empty_s),
      .count_o (unused_tx_count_s)
   );

   apb_uart_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clk_i   (PCLK),
      .rst_ni  (PRESETN),
      .push_i  (RX_VALID),
      .pop_i   (rx_pop_s),
      .wdata_i (RX_DATA),
      .rdata_o (rx_head_s),
      .full_o  (rx_full_s),
      .empty_o (rx_empty_s),
      .count_o (rx_count_s)
   );

   assign PRDATA   = rdata_s;
   assign PSLVERR  = err_s;
   assign PREADY   = 1'b1;
   assign TX_VALID = ~tx_empty_s;
   assign UART_EN  = ctrl_q[CTRL_UART_EN];
   assign BAUD_VAL = baud_q;
   assign INT      = int_q;

endmodule

// File: tb/tb_apb_uart_regif.sv
module tb_apb_uart_regif;
   logic        PCLK = 1'b0;
   logic        PRESETN, PSEL, PENABLE, PWRITE;
   logic [4:0]  PADDR;
   logic [31:0] PWDATA, PRDATA;
   logic        PREADY, PSLVERR;
   logic [7:0]  TX_DATA, RX_DATA;
   logic        TX_VALID, TX_READY, RX_VALID, UART_EN, INT;
   logic [12:0] BAUD_VAL;

   always #5 PCLK = ~PCLK;

   apb_uart_regif dut (
      .PCLK(PCLK), .PRESETN(PRESETN), .PSEL(PSEL), .PENABLE(PENABLE),
      .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
      .PREADY(PREADY), .PSLVERR(PSLVERR), .TX_DATA(TX_DATA), .TX_VALID(TX_VALID),
      .TX_READY(TX_READY), .RX_DATA(RX_DATA), .RX_VALID(RX_VALID),
      .BAUD_VAL(BAUD_VAL), .UART_EN(UART_EN), .INT(INT)
   );

   // behavioural reference: byte queues plus register values
   logic [7:0]  txq[$];
   logic [7:0]  rxq[$];
   logic [2:0]  m_ctrl = 3'd0;
   logic [12:0] m_baud = 13'd0;
   bit          m_ov = 1'b0;
   bit          m_int = 1'b0;

   int          n_chk = 0, n_pass = 0, n_fail = 0;
   logic [31:0] obs_rdata;
   logic        obs_err;
   bit          rnd_mode = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] m_status();
      return {16'h0, 8'(rxq.size()), 3'b000, m_ov, rxq.size() == 16,
              rxq.size() != 0, txq.size() == 0, txq.size() == 16};
   endfunction

   // one clock cycle: predict, check at negedge, advance model at posedge
   task automatic cyc();
      bit          acc, tx_push, rx_pop, clr, int_n;
      int          off;
      logic [31:0] e_rd;
      bit          e_err;
      acc = PSEL && PENABLE && PRESETN;
      off = int'(PADDR) & 32'h1C;
      e_rd = 32'h0; e_err = 1'b0; tx_push = 1'b0; rx_pop = 1'b0; clr = 1'b0;
      if (acc) begin
         case (off)
            'h00: if (PWRITE && txq.size() < 16) tx_push = 1'b1; else e_err = 1'b1;
            'h04: if (!PWRITE && rxq.size() > 0) begin e_rd = 32'(rxq[0]); rx_pop = 1'b1; end
                  else e_err = 1'b1;
            'h08: if (PWRITE) e_err = 1'b1; else e_rd = m_status();
            'h0C: if (!PWRITE) e_rd = 32'(m_ctrl);
            'h10: if (!PWRITE) e_rd = 32'(m_baud);
            'h14: if (PWRITE) clr = PWDATA[4]; else e_err = 1'b1;
            default: e_err = 1'b1;
         endcase
      end
      @(negedge PCLK);
      obs_rdata = PRDATA;
      obs_err   = PSLVERR;
      check("prdata", PRDATA, e_rd);
      check("pslverr", 32'(PSLVERR), 32'(e_err));
      check("pready", 32'(PREADY), 32'd1);
      check("tx_valid", 32'(TX_VALID), 32'(txq.size() != 0));
      if (txq.size() != 0) check("tx_data", 32'(TX_DATA), 32'(txq[0]));
      check("int", 32'(INT), 32'(m_int));
      check("baud_val", 32'(BAUD_VAL), 32'(m_baud));
      check("uart_en", 32'(UART_EN), 32'(m_ctrl[0]));
      @(posedge PCLK);
      if (!PRESETN) begin
         txq.delete(); rxq.delete();
         m_ctrl = 3'd0; m_baud = 13'd0; m_ov = 1'b0; m_int = 1'b0;
      end else begin
         int_n = (m_ctrl[1] && rxq.size() != 0) || (m_ctrl[2] && txq.size() == 0) || m_ov;
         if (TX_READY && txq.size() != 0) void'(txq.pop_front());
         if (tx_push) txq.push_back(PWDATA[7:0]);
         if (acc && PWRITE && off == 'h0C) m_ctrl = PWDATA[2:0];
         if (acc && PWRITE && off == 'h10) m_baud = PWDATA[12:0];
         if (rx_pop) void'(rxq.pop_front());
         if (clr) m_ov = 1'b0;
         if (RX_VALID) begin
            if (rxq.size() < 16) rxq.push_back(RX_DATA);
            else m_ov = 1'b1;
         end
         m_int = int_n;
      end
      #1;
   endtask

   task automatic side();
      if (rnd_mode) begin
         RX_VALID = ($urandom_range(0, 3) == 0);
         RX_DATA  = 8'($urandom);
         TX_READY = 1'($urandom_range(0, 1));
      end
   endtask

   task automatic apb(input logic wr, input logic [4:0] a, input logic [31:0] d);
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = a; PWDATA = d;
      side(); cyc();
      PENABLE = 1'b1;
      side(); cyc();
      PSEL = 1'b0; PENABLE = 1'b0;
   endtask

   task automatic rx_push(input logic [7:0] b);
      RX_VALID = 1'b1; RX_DATA = b; cyc(); RX_VALID = 1'b0;
   endtask

   initial begin
      PRESETN = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
      PADDR = 5'h0; PWDATA = 32'h0; TX_READY = 1'b0; RX_VALID = 1'b0; RX_DATA = 8'h0;
      @(posedge PCLK); #1;
      cyc(); cyc();
      PRESETN = 1'b1;
      // reset state
      apb(1'b0, 5'h08, 32'h0);
      check("rst_status", obs_rdata, 32'h0000_0002);
      check("rst_err", 32'(obs_err), 32'd0);
      check("rst_int", 32'(INT), 32'd0);
      check("rst_txvalid", 32'(TX_VALID), 32'd0);
      // BAUD / CTRL
      apb(1'b1, 5'h10, 32'h0000_01A5);
      check("baud_out", 32'(BAUD_VAL), 32'h1A5);
      apb(1'b1, 5'h0C, 32'h0000_0003);
      check("uart_en_out", 32'(UART_EN), 32'd1);
      apb(1'b0, 5'h10, 32'h0);
      check("baud_rd", obs_rdata, 32'h1A5);
      apb(1'b0, 5'h0C, 32'h0);
      check("ctrl_rd", obs_rdata, 32'h3);
      // TX fill, overflow, drain
      TX_READY = 1'b0;
      for (int i = 0; i < 16; i++) apb(1'b1, 5'h00, 32'h41 + 32'(i));
      apb(1'b1, 5'h00, 32'h99);
      check("tx_full_err", 32'(obs_err), 32'd1);
      apb(1'b0, 5'h08, 32'h0);
      check("tx_full_bit", 32'(obs_rdata[0]), 32'd1);
      TX_READY = 1'b1;
      for (int i = 0; i < 16; i++) begin
         check("drain_valid", 32'(TX_VALID), 32'd1);
         check("drain_data", 32'(TX_DATA), 32'h41 + 32'(i));
         cyc();
      end
      check("drain_done", 32'(TX_VALID), 32'd0);
      TX_READY = 1'b0;
      // RX overflow
      for (int i = 0; i < 17; i++) rx_push(8'(i));
      apb(1'b0, 5'h08, 32'h0);
      check("rx_ovf_status", obs_rdata, 32'h0000_101E);
      for (int i = 0; i < 16; i++) begin
         apb(1'b0, 5'h04, 32'h0);
         check("rx_rd", obs_rdata, 32'(i));
      end
      apb(1'b0, 5'h04, 32'h0);
      check("rx_empty_err", 32'(obs_err), 32'd1);
      check("rx_empty_data", obs_rdata, 32'h0);
      apb(1'b1, 5'h14, 32'h10);
      apb(1'b0, 5'h08, 32'h0);
      check("ovr_cleared", 32'(obs_rdata[4]), 32'd0);
      // full RX with simultaneous read and push
      for (int i = 0; i < 16; i++) rx_push(8'h80 + 8'(i));
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 5'h04; cyc();
      PENABLE = 1'b1; RX_VALID = 1'b1; RX_DATA = 8'hAA; cyc();
      RX_VALID = 1'b0; PSEL = 1'b0; PENABLE = 1'b0;
      check("simul_rd", obs_rdata, 32'h80);
      check("simul_err", 32'(obs_err), 32'd0);
      apb(1'b0, 5'h08, 32'h0);
      check("simul_status", obs_rdata, 32'h0000_100E);
      for (int i = 0; i < 16; i++) begin
         apb(1'b0, 5'h04, 32'h0);
         check("simul_drain", obs_rdata, (i == 15) ? 32'hAA : 32'h81 + 32'(i));
      end
      // unmapped access and interrupt latency
      apb(1'b0, 5'h18, 32'h0);
      check("unmapped_err", 32'(obs_err), 32'd1);
      check("unmapped_data", obs_rdata, 32'h0);
      rx_push(8'h55);
      check("int_before", 32'(INT), 32'd0);
      cyc();
      check("int_set", 32'(INT), 32'd1);
      apb(1'b0, 5'h04, 32'h0);
      check("int_hold", 32'(INT), 32'd1);
      cyc();
      check("int_clear", 32'(INT), 32'd0);
      // reset during an access phase
      for (int i = 0; i < 3; i++) apb(1'b1, 5'h00, 32'h60 + 32'(i));
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 5'h1C; PWDATA = 32'h99; cyc();
      PENABLE = 1'b1; PRESETN = 1'b0; cyc();
      check("rst_mid_err", 32'(obs_err), 32'd0);
      PSEL = 1'b0; PENABLE = 1'b0; PRESETN = 1'b1;
      check("rst_mid_txvalid", 32'(TX_VALID), 32'd0);
      apb(1'b0, 5'h08, 32'h0);
      check("rst_mid_status", obs_rdata, 32'h2);
      // randomized traffic against the model
      rnd_mode = 1'b1;
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 99) == 0) begin
            PRESETN = 1'b0; side(); cyc(); PRESETN = 1'b1;
         end
         apb(1'($urandom_range(0, 1)),
             5'($urandom_range(0, 7) * 4 + $urandom_range(0, 3)),
             $urandom);
      end
      rnd_mode = 1'b0; RX_VALID = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
